// File: rtl/axi_slv_pkg.sv
// Shared types and constants for the AXI4 burst responder memory.
package axi_slv_pkg;

  // One burst in flight at a time; the RAM port is shared by both directions.
  typedef enum logic [1:0] {
    StIdle,
    StWdata,
    StWresp,
    StRdata
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned BEAT_BYTES = 4;

  // Back-pressure LFSR: Fibonacci, taps 8,6,5,4 (bits 7,5,4,3), shifts left.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic lfsr_fb(input logic [7:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/axi_slv_bram.sv
// Single-port RAM, 32-bit words with byte write enables and registered read.
// Output holds its last value when not enabled; the array has no reset.
module axi_slv_bram
  import axi_slv_pkg::*;
#(
  parameter int unsigned MEM_ADDR_W = 12
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [BEAT_BYTES-1:0]   we,
  input  logic [MEM_ADDR_W-1:0]   addr,
  input  logic [8*BEAT_BYTES-1:0] wdata,
  output logic [8*BEAT_BYTES-1:0] rdata
);

  logic [8*BEAT_BYTES-1:0] mem [2**MEM_ADDR_W];

  // Byte-granular write and synchronous read on the same port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BEAT_BYTES; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_burst_slave_mem.sv
// AXI4 INCR-burst responder backed by byte-enabled on-chip RAM.
// 32-bit beats, one burst at a time, round-robin between AW and AR.
// Optional AXI_SLV_STALL_EN: LFSR-driven pseudo-random ready/read stalls.
module axi_burst_slave_mem
  import axi_slv_pkg::*;
#(
  parameter int unsigned           AXI_ADDR_W = 32,
  parameter int unsigned           AXI_ID_W   = 1,
  parameter int unsigned           MEM_ADDR_W = 12,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXI_ID_W-1:0]   s_axi_awid,
  input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [AXI_ID_W-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [AXI_ID_W-1:0]   s_axi_arid,
  input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [AXI_ID_W-1:0]   s_axi_rid,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int unsigned UpLsb = MEM_ADDR_W + 2;

  state_e                state_q, state_d;
  logic                  prio_q;     // 0: write wins a collision, 1: read wins
  logic [AXI_ID_W-1:0]   id_q;
  logic [MEM_ADDR_W-1:0] idx_q;
  logic [7:0]            cnt_q;      // write: beats left minus one; read: len
  logic [7:0]            rd_beat_q;  // index of the next beat to issue to the RAM
  logic                  rd_left_q;  // beats still to be issued
  logic                  err_q;
  logic                  rvalid_q;
  logic                  rlast_q;

  logic                  stall;
  logic                  aw_hs, ar_hs, w_hs, r_hs, rd_en;
  logic                  aw_err, ar_err;
  logic [3:0]            ram_we;
  logic [31:0]           ram_rdata;

  // Byte-lane bits are ignored: the master aligns and uses strobes.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

`ifdef AXI_SLV_STALL_EN
  logic [7:0] lfsr_q;

  // Free-running stall source, advances every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_fb(lfsr_q)};
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign aw_err = s_axi_awaddr[AXI_ADDR_W-1:UpLsb] != BASE_ADDR[AXI_ADDR_W-1:UpLsb];
  assign ar_err = s_axi_araddr[AXI_ADDR_W-1:UpLsb] != BASE_ADDR[AXI_ADDR_W-1:UpLsb];

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign r_hs  = rvalid_q & s_axi_rready;
  // Issue a read whenever the output slot is empty or being drained this cycle.
  assign rd_en = (state_q == StRdata) & rd_left_q & (~rvalid_q | s_axi_rready) & ~stall;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (aw_hs)      state_d = StWdata;
        else if (ar_hs) state_d = StRdata;
      end
      StWdata: if (w_hs && s_axi_wlast) state_d = StWresp;
      StWresp: if (s_axi_bready)        state_d = StIdle;
      StRdata: if (r_hs && rlast_q)     state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: address readies only in idle, the collision loser held low.
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    unique case (state_q)
      StIdle: begin
        if (!rst && !stall) begin
          s_axi_awready = ~(s_axi_arvalid & prio_q);
          s_axi_arready = ~(s_axi_awvalid & ~prio_q);
        end
      end
      StWdata: s_axi_wready = ~stall;
      StWresp: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  // Burst context: latched on acceptance, stepped per write beat or read issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q    <= 1'b0;
      id_q      <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      rd_beat_q <= '0;
      rd_left_q <= 1'b0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      if (aw_hs || ar_hs) begin
        prio_q    <= ~prio_q;
        id_q      <= aw_hs ? s_axi_awid : s_axi_arid;
        idx_q     <= aw_hs ? s_axi_awaddr[MEM_ADDR_W+1:2] : s_axi_araddr[MEM_ADDR_W+1:2];
        cnt_q     <= aw_hs ? s_axi_awlen : s_axi_arlen;
        err_q     <= aw_hs ? aw_err : ar_err;
        rd_beat_q <= '0;
        rd_left_q <= ar_hs;
      end
      if (w_hs) begin
        idx_q <= idx_q + 1'b1;
        cnt_q <= cnt_q - 8'd1;
        // wlast must coincide with the final counted beat; any mismatch is sticky.
        if (s_axi_wlast != (cnt_q == 8'd0)) err_q <= 1'b1;
      end
      if (rd_en) begin
        idx_q     <= idx_q + 1'b1;
        rd_beat_q <= rd_beat_q + 8'd1;
        rlast_q   <= (rd_beat_q == cnt_q);
        if (rd_beat_q == cnt_q) rd_left_q <= 1'b0;
        rvalid_q  <= 1'b1;
      end else if (r_hs) begin
        rvalid_q  <= 1'b0;
      end
    end
  end

  assign ram_we = (w_hs && !err_q) ? s_axi_wstrb : 4'b0000;

  axi_slv_bram #(
    .MEM_ADDR_W(MEM_ADDR_W)
  ) u_bram (
    .clk  (clk),
    .en   (rd_en),
    .we   (ram_we),
    .addr (idx_q),
    .wdata(s_axi_wdata),
    .rdata(ram_rdata)
  );

  assign s_axi_bid    = id_q;
  assign s_axi_rid    = id_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rlast  = rvalid_q & rlast_q;
  assign s_axi_rdata  = (rvalid_q && !err_q) ? ram_rdata : 32'h0;
  assign s_axi_rresp  = (rvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Scoreboard bench for axi_burst_slave_mem: drivers push expected responses
// from a word-array memory model; a monitor pops and compares on handshakes.
module tb_axi_burst_slave_mem;

  localparam int unsigned TMO   = 2000;
  localparam int unsigned WORDS = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic        s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  axi_burst_slave_mem #(
    .AXI_ADDR_W(32), .AXI_ID_W(1), .MEM_ADDR_W(12), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      exp_b[$];
  r_exp_t      exp_r[$];
  logic [31:0] mem_m [WORDS];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  bit          prio_m;        // 0: next collision goes to the write
  bit          rr_directed;
  int          checks, errors;
  int unsigned cyc, t_aw, t_ar;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit in_range(logic [31:0] a);
    return (a >> 14) == 32'h0;  // 16 KiB window at base 0
  endfunction

  function automatic int unsigned widx(logic [31:0] a, int b);
    return ((a >> 2) + b) % WORDS;
  endfunction

  function automatic void model_write(logic [31:0] a, int len, logic id);
    bit ok = in_range(a);
    if (ok) begin
      for (int b = 0; b <= len; b++)
        for (int i = 0; i < 4; i++)
          if (ws[b][i]) mem_m[widx(a, b)][8*i +: 8] = wd[b][8*i +: 8];
    end
    exp_b.push_back('{id: id, resp: ok ? 2'b00 : 2'b10});
    prio_m = ~prio_m;
  endfunction

  function automatic void model_read(logic [31:0] a, int len, logic id);
    bit ok = in_range(a);
    for (int b = 0; b <= len; b++)
      exp_r.push_back('{id: id, data: ok ? mem_m[widx(a, b)] : 32'h0,
                        resp: ok ? 2'b00 : 2'b10, last: (b == len)});
    prio_m = ~prio_m;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic fail_timeout(input string what);
    checks++;
    errors++;
    $display("FAIL timeout %s: no handshake in %0d cycles, required one", what, TMO);
  endtask

  task automatic fill_rand(input int len, input bit full);
    for (int b = 0; b <= len; b++) begin
      wd[b] = $urandom;
      ws[b] = full ? 4'hF : 4'($urandom_range(0, 15));
    end
  endtask

  task automatic aw_phase(input logic [31:0] a, input int len, input logic id);
    int n = 0;
    s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = 8'(len); s_axi_awvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_awready && n < TMO) begin n++; @(negedge clk); end
    if (s_axi_awready) begin t_aw = cyc; model_write(a, len, id); end
    else fail_timeout("aw");
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic w_phase(input int len, input int upto, input bit gaps);
    for (int b = 0; b <= len && b < upto; b++) begin
      int n = 0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      s_axi_wvalid = 1'b1; s_axi_wdata = wd[b]; s_axi_wstrb = ws[b]; s_axi_wlast = (b == len);
      @(negedge clk);
      while (!s_axi_wready && n < TMO) begin n++; @(negedge clk); end
      if (!s_axi_wready) begin
        fail_timeout("w");
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        break;
      end
      @(posedge clk); #1;
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input logic id, input bit gaps);
    aw_phase(a, len, id);
    w_phase(len, len + 1, gaps);
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input logic id);
    int n = 0;
    s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = 8'(len); s_axi_arvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_arready && n < TMO) begin n++; @(negedge clk); end
    if (s_axi_arready) begin t_ar = cyc; model_read(a, len, id); end
    else fail_timeout("ar");
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 4 * TMO) begin
      n++; @(negedge clk);
    end
    if (exp_b.size() != 0 || exp_r.size() != 0) fail_timeout("drain");
    @(posedge clk); #1;
  endtask

  task automatic collide(input logic [31:0] wa, input int wl, input logic [31:0] ra, input int rl);
    bit exp_w_first = (prio_m == 1'b0);
    fill_rand(wl, 1'b0);
    fork
      do_write(wa, wl, 1'b0, 1'b1);
      do_read(ra, rl, 1'b1);
    join
    checks++;
    if ((t_aw < t_ar) != exp_w_first) begin
      errors++;
      $display("FAIL collision order: write_first=%0d, required %0d", t_aw < t_ar, exp_w_first);
    end
  endtask

  // Random response back-pressure; rready handed over to directed tests when asked.
  initial begin
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      s_axi_bready = ($urandom_range(0, 3) != 0);
      if (!rr_directed) s_axi_rready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every B and R handshake against the scoreboard queues.
  initial begin
    bit          prev_hold = 1'b0;
    logic [31:0] prev_rdata;
    logic        prev_rlast;
    forever begin
      @(negedge clk);
      if (rst) begin prev_hold = 1'b0; continue; end
      if (prev_hold) begin
        checks++;
        if (!(s_axi_rvalid && s_axi_rdata === prev_rdata && s_axi_rlast === prev_rlast)) begin
          errors++;
          $display("FAIL r hold: got v=%0d d=%h l=%0d, required v=1 d=%h l=%0d",
                   s_axi_rvalid, s_axi_rdata, s_axi_rlast, prev_rdata, prev_rlast);
        end
      end
      prev_hold  = s_axi_rvalid && !s_axi_rready;
      prev_rdata = s_axi_rdata;
      prev_rlast = s_axi_rlast;
      if (s_axi_bvalid && s_axi_bready) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL b resp: got id=%0d resp=%0d, required no response", s_axi_bid, s_axi_bresp);
        end else begin
          b_exp_t e;
          e = exp_b.pop_front();
          if ({s_axi_bid, s_axi_bresp} !== e) begin
            errors++;
            $display("FAIL b resp: got id=%0d resp=%0d, required id=%0d resp=%0d",
                     s_axi_bid, s_axi_bresp, e.id, e.resp);
          end
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        checks++;
        if (exp_r.size() == 0) begin
          errors++;
          $display("FAIL r beat: got d=%h, required no beat", s_axi_rdata);
        end else begin
          r_exp_t e;
          e = exp_r.pop_front();
          if ({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} !== e) begin
            errors++;
            $display("FAIL r beat: got id=%0d d=%h resp=%0d last=%0d, required id=%0d d=%h resp=%0d last=%0d",
                     s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, e.id, e.data, e.resp, e.last);
          end
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rr_directed = 1'b0;
    s_axi_awvalid = 0; s_axi_arvalid = 0; s_axi_wvalid = 0; s_axi_wlast = 0;
    s_axi_awid = 0; s_axi_arid = 0; s_axi_awaddr = 0; s_axi_araddr = 0;
    s_axi_awlen = 0; s_axi_arlen = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
    repeat (3) @(negedge clk);
    chk("rst awready", 32'(s_axi_awready), 32'd0);
    chk("rst arready", 32'(s_axi_arready), 32'd0);
    chk("rst wready",  32'(s_axi_wready),  32'd0);
    chk("rst bvalid",  32'(s_axi_bvalid),  32'd0);
    chk("rst rvalid",  32'(s_axi_rvalid),  32'd0);
    chk("rst rlast",   32'(s_axi_rlast),   32'd0);
    chk("rst bresp",   32'(s_axi_bresp),   32'd0);
    chk("rst rresp",   32'(s_axi_rresp),   32'd0);
    chk("rst bid",     32'(s_axi_bid),     32'd0);
    chk("rst rid",     32'(s_axi_rid),     32'd0);
    chk("rst rdata",   s_axi_rdata,        32'd0);
    @(posedge clk); #1; rst = 1'b0;
    prio_m = 1'b0;

    // Prefill the whole RAM so every later read has a known value.
    for (int i = 0; i < 16; i++) begin
      fill_rand(255, 1'b1);
      do_write(32'(i * 1024), 255, 1'(i), 1'b0);
    end
    drain();

    // Single beat write and readback; B follows the wlast handshake by one cycle.
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(32'h0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bvalid latency", 32'(s_axi_bvalid), 32'd1);
    @(posedge clk); #1;
    do_read(32'h0, 0, 1'b1);
    drain();

    // Partial strobes over a known background.
    for (int b = 0; b < 4; b++) begin wd[b] = 32'h11111111; ws[b] = 4'hF; end
    do_write(32'h10, 3, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) wd[b] = 32'hAABBCCDD;
    ws[0] = 4'b1100; ws[1] = 4'b1111; ws[2] = 4'b1111; ws[3] = 4'b0011;
    do_write(32'h10, 3, 1'b1, 1'b1);
    do_read(32'h10, 3, 1'b0);
    drain();

    // 256-beat read with rready dropped on cycles 3..7 after first rvalid.
    rr_directed = 1'b1; s_axi_rready = 1'b1;
    fork
      do_read(32'h400, 255, 1'b1);
      begin
        int n = 0;
        int k = 0;
        bit done = 1'b0;
        @(negedge clk);
        while (!s_axi_rvalid && n < TMO) begin n++; @(negedge clk); end
        if (!s_axi_rvalid) fail_timeout("first rvalid");
        else begin
          chk("first rvalid latency", cyc, t_ar + 2);
          while (!done && k < 400) begin
            if (s_axi_rvalid && s_axi_rready && s_axi_rlast) done = 1'b1;
            else begin
              @(posedge clk); #1; k++;
              s_axi_rready = !(k >= 3 && k <= 7);
              @(negedge clk);
            end
          end
          chk("read256 rlast cycle", 32'(k), 32'd260);
        end
      end
    join
    drain();
    rr_directed = 1'b0;

    // Collisions: arrange write priority, then read priority for the second.
    if (prio_m) do_read(32'h0, 0, 1'b0);
    collide(32'h200, 3, 32'h200, 3);
    do_read(32'h40, 1, 1'b0);
    collide(32'h300, 2, 32'h300, 2);
    drain();

    // Out-of-range write is absorbed without touching RAM; reads return zero.
    fill_rand(3, 1'b1);
    do_write(32'h10000, 3, 1'b1, 1'b1);
    do_read(32'h0, 3, 1'b0);
    do_read(32'h10000, 3, 1'b1);
    // Index wrap at the top of the RAM.
    fill_rand(3, 1'b0);
    do_write(32'h3FF8, 3, 1'b0, 1'b0);
    do_read(32'h3FF8, 3, 1'b1);
    drain();

    // Reset during beat 3 of an 8-beat write.
    fill_rand(7, 1'b1);
    aw_phase(32'h800, 7, 1'b0);
    w_phase(7, 3, 1'b0);
    s_axi_wvalid = 1'b1; s_axi_wdata = wd[3]; s_axi_wstrb = ws[3]; s_axi_wlast = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst wready", 32'(s_axi_wready), 32'd0);
    chk("mid-rst bvalid", 32'(s_axi_bvalid), 32'd0);
    exp_b.delete(); exp_r.delete(); prio_m = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge clk);
    chk("post-rst idle awready", 32'(s_axi_awready), 32'd1);
    chk("post-rst wready", 32'(s_axi_wready), 32'd0);
    @(posedge clk); #1;
    fill_rand(7, 1'b1);
    do_write(32'h800, 7, 1'b1, 1'b0);
    do_read(32'h800, 7, 1'b0);
    drain();

    // Randomised mix of writes, reads and collisions.
    for (int i = 0; i < 40; i++) begin
      int kind;
      int len;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      len  = $urandom_range(0, 31);
      a    = 32'($urandom_range(0, 4095)) << 2;
      if ($urandom_range(0, 7) == 0) a = a + 32'h10000;
      if (kind == 0) begin
        fill_rand(len, 1'b0);
        do_write(a, len, 1'($urandom), 1'b1);
      end else if (kind == 1) begin
        do_read(a, len, 1'($urandom));
      end else begin
        collide(a, len, 32'($urandom_range(0, 4095)) << 2, $urandom_range(0, 15));
      end
    end
    drain();

    chk("queues empty", 32'(exp_b.size() + exp_r.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_slave_mem.md
Name: axi_burst_slave_mem

Overview:
- AXI4 responder (slave) backed by on-chip byte-enabled RAM.
- Accepts the 32-bit INCR bursts (1–256 beats, partial first/last strobes) issued by the team's byte-aligning DMA master.
- Serves as the memory target in DMA simulation and on-FPGA loopback, and as a scratch buffer on the interconnect.
- Handles one burst at a time: a single FSM shares the RAM port between read and write.

Parameters:
AXI_ADDR_W, 32, AXI address width
AXI_ID_W, 1, AXI ID width
MEM_ADDR_W, 12, log2 of RAM depth in 32-bit words (default 16 KiB)
BASE_ADDR, 0, byte base address; bits above MEM_ADDR_W+2 must match or the burst is SLVERR

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_axi_awid  in  AXI_ID_W  write burst ID
s_axi_awaddr  in  AXI_ADDR_W  write start byte address
s_axi_awlen  in  8  beats-1
s_axi_awvalid/s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid/s_axi_wready  in/out  1  W handshake
s_axi_bid  out  AXI_ID_W  echoed awid
s_axi_bresp  out  2  00 OKAY / 10 SLVERR
s_axi_bvalid/s_axi_bready  out/in  1  B handshake
s_axi_arid  in  AXI_ID_W  read burst ID
s_axi_araddr  in  AXI_ADDR_W  read start byte address
s_axi_arlen  in  8  beats-1
s_axi_arvalid/s_axi_arready  in/out  1  AR handshake
s_axi_rid  out  AXI_ID_W  echoed arid
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  OKAY/SLVERR
s_axi_rlast  out  1  last read beat
s_axi_rvalid/s_axi_rready  out/in  1  R handshake

Behaviour:
- Reset and clock: reset rst, asynchronous, active-high; clock clk.
- Reset values: all ready/valid/last = 0, bresp = rresp = 0, bid = rid = 0, rdata = 0, FSM in IDLE, priority bit = write.
- AWSIZE is fixed at 4 bytes and AWBURST at INCR; neither is a port. lock, cache, prot and qos are not present.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE:
  - awready and arready are combinational, asserted only in IDLE.
  - If both AW and AR are valid, the priority bit selects the winner; the bit toggles after every accepted burst (round robin).
  - The losing ready is held low.
  - On acceptance, latch: ID, word index = addr[MEM_ADDR_W+1:2], beat counter = len, and err = (upper address bits != BASE_ADDR upper bits).
  - Address bits [1:0] are ignored; the master supplies aligned addresses plus strobes.
- WDATA:
  - wready = 1.
  - Each W beat writes the RAM at the index with wstrb (4 byte enables), then index+1 and counter-1.
  - When err = 1 the beat is accepted but the write is suppressed.
  - Index wraps modulo 2^MEM_ADDR_W.
  - On wlast, go to WRESP.
  - If wlast arrives with counter != 0, or counter reaches 0 without wlast, set err.
  - Beats after a missing wlast are still absorbed until wlast.
- WRESP:
  - bvalid = 1, bresp = err ? SLVERR : OKAY, bid = latched ID.
  - Hold until bready, then go to IDLE.
  - bvalid is first asserted one cycle after the wlast handshake.
- RDATA:
  - RAM read is synchronous with 1-cycle latency.
  - Read enable = issued-beats-remaining && (!rvalid || rready).
  - rvalid is set the cycle after an enabled read; it clears on rready when no read was issued.
  - Full throughput: one beat per cycle while rready = 1.
  - First rvalid occurs 2 cycles after the AR handshake.
  - rdata is held stable while rvalid && !rready.
  - rlast = 1 on the beat whose index equals len.
  - err: rdata = 0 and rresp = SLVERR on every beat.
  - After the rlast handshake, go to IDLE.
- Back-to-back: IDLE is visited for one cycle between bursts; no AW/AR is accepted during an active burst.
- Reset mid-burst: FSM returns to IDLE immediately and all valids drop. RAM contents are undefined for the interrupted burst only.

Optional Feature:
- Macro AXI_SLV_STALL_EN.
- With it: an 8-bit Fibonacci LFSR (seed 8'hA5, taps 8,6,5,4) advances every cycle. When lfsr[0] = 1, it forces wready = 0, read enable = 0, and awready = arready = 0, stressing master back-pressure. Protocol rules are unchanged: valid and data stay stable.
- Without it: no LFSR, no stalls; ready signals follow the FSM only.

Decomposition:
- Package axi_slv_pkg holds:
  - FSM state encoding;
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - BEAT_BYTES = 4;
  - LFSR seed and taps.
- One sub-module, axi_slv_bram: single-port, MEM_ADDR_W x 32, 4 byte-write enables, synchronous read. It holds its output when not enabled and has no reset on the array.

Test Plan:
- Single beat: AW addr 0x0, len 0, wdata 0xDEADBEEF, wstrb 4'hF -> bresp OKAY; AR addr 0x0, len 0 -> rdata 0xDEADBEEF, rlast = 1.
- Partial strobes: 4-beat write at 0x10 with strbs 1100/1111/1111/0011 over a prefilled 0x11111111 pattern -> word 0x10 = 0xAABB1111, word 0x1C = 0x1111CCDD. Readback matches.
- 256-beat read at 0x400 with rready low on cycles 3–7 -> 256 beats in order; rdata stable during the stall; rlast only on beat 255; one beat per cycle otherwise.
- AW and AR valid in the same cycle, twice -> write served first, then the read; on the next collision the read is served first.
- Out-of-range awaddr BASE_ADDR + 0x10000 -> beats absorbed, bresp SLVERR, RAM unchanged. The same address read -> rdata 0, rresp SLVERR.
- rst pulsed during beat 3 of an 8-beat write -> wready = 0 and FSM in IDLE next cycle; a new burst after reset completes with OKAY.
